// File: rtl/timer_dev.sv
// Countdown timer peripheral on the data-memory store/load path; CTRL/PRESET/COUNT registers, irq on expiry.
// Reads are combinational, writes land on the clock edge; irq is registered. The device never stalls the core.
module timer_dev #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_PRESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              int_flag_q, int_flag_d;
  logic              irq_q;
  logic              en, auto_reload, wr_ctrl, wr_preset, fsm_set;
  logic              unused_addr;

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl     = we && (addr[3:2] == 2'd0);
  assign wr_preset   = we && (addr[3:2] == 2'd1);
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    int_flag_d = int_flag_q;
    fsm_set    = 1'b0;
    case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = en ? S_CNT : S_IDLE;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          count_d = '0;
          state_d = S_INT;
          fsm_set = 1'b1;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          int_flag_d = 1'b0;
          state_d    = en ? S_LOAD : S_IDLE;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Software writes override the FSM's EN clear, but an expiry on the same edge still sets the flag.
    if (wr_ctrl)   ctrl_d   = wdata[3:0];
    if (wr_preset) preset_d = wdata;
    if (wr_ctrl || wr_preset) int_flag_d = 1'b0;
    if (fsm_set)   int_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= RESET_PRESET;
      count_q    <= '0;
      int_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      int_flag_q <= int_flag_d;
      irq_q      <= int_flag_d & ctrl_d[3];
    end
  end

  always_comb begin
    case (addr[3:2])
      2'd0:    rdata = {{(DATA_W-4){1'b0}}, ctrl_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
